// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-size checks, schedule geometry,
// GF(2^8) doubling and the expansion engine state encoding.
package aes_pkg;

  typedef enum logic {IDLE, GEN} state_e;

  function automatic bit key_bits_ok(input int kb);
    return (kb == 128) || (kb == 192) || (kb == 256);
  endfunction

  function automatic int nk_of(input int kb);
    return kb / 32;
  endfunction

  function automatic int nr_of(input int kb);
    return kb / 32 + 6;
  endfunction

  function automatic int nw_of(input int kb);
    return 4 * (nr_of(kb) + 1);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  // Row 0 occupies the top bits, so entry n sits at bit offset (255-n)*8.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_o = SBOX[{~in_i, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES key schedule: one 32-bit word per clock into a word store,
// with a registered random-access round-key read port.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key,
  output logic                busy,
  output logic                done,
  input  logic [3:0]          rk_addr,
  output logic [127:0]        rk_data
);

  generate
    if (!key_bits_ok(KEY_BITS)) begin : g_bad_key
      $error("aes_key_expand: KEY_BITS must be 128, 192 or 256");
    end
  endgenerate

  localparam int NK = nk_of(KEY_BITS);
  localparam int NR = nr_of(KEY_BITS);
  localparam int NW = nw_of(KEY_BITS);
  localparam int IW = $clog2(NW);

  state_e          state_q;
  logic [IW-1:0]   i_q;
  logic [2:0]      m_q;     // i mod NK
  logic [7:0]      rcon_q;
  logic            busy_q, done_q;
  logic [31:0]     w_q [NW];
  logic [127:0]    rk_q, rk_d;

  logic [31:0] prev, rot, sub, temp, new_w;

  assign prev = w_q[i_q - IW'(1)];
  assign rot  = (m_q == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

  for (genvar b = 0; b < 4; b++) begin : g_sub
    aes_sbox u_sbox (.in_i(rot[8*b +: 8]), .out_o(sub[8*b +: 8]));
  end

  always_comb begin
    temp = prev;
    if (m_q == 3'd0)                   temp = sub ^ {rcon_q, 24'h0};
    else if (NK == 8 && m_q == 3'd4)   temp = sub;
    new_w = w_q[i_q - IW'(NK)] ^ temp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      m_q     <= '0;
      rcon_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int k = 0; k < NW; k++) w_q[k] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          for (int k = 0; k < NK; k++) w_q[k] <= key[KEY_BITS-1-32*k -: 32];
          i_q     <= IW'(NK);
          m_q     <= 3'd0;
          rcon_q  <= 8'h01;
          busy_q  <= 1'b1;
          state_q <= GEN;
        end
        GEN: begin
          w_q[i_q] <= new_w;
          if (m_q == 3'd0) rcon_q <= xtime(rcon_q);
          if (i_q == IW'(NW-1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            i_q <= i_q + IW'(1);
            m_q <= (m_q == 3'(NK-1)) ? 3'd0 : m_q + 3'd1;
          end
        end
      endcase
    end
  end

  // Read port sees the store as it stands, including a half-rewritten schedule.
  logic [IW-1:0] base;
  assign base = IW'({rk_addr, 2'b00});

  always_comb begin
    rk_d = '0;
    if (rk_addr <= 4'(NR))
      rk_d = {w_q[base], w_q[base + IW'(1)], w_q[base + IW'(2)], w_q[base + IW'(3)]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rk_q <= '0;
    else     rk_q <= rk_d;
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rk_data = rk_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench: one engine per key size, FIPS-197 vectors, back-to-back
// expansion, ignored mid-run start and mid-run reset.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   start_s = '0;
  logic [255:0] key_s = '0;
  logic [3:0]   addr_s [3];
  wire  [2:0]   busy_s, done_s;
  wire  [127:0] data_s [3];

  always #5 clk = ~clk;

  aes_key_expand #(.KEY_BITS(128)) u_k128 (
    .clk(clk), .rst(rst), .start(start_s[0]), .key(key_s[127:0]),
    .busy(busy_s[0]), .done(done_s[0]), .rk_addr(addr_s[0]), .rk_data(data_s[0]));
  aes_key_expand #(.KEY_BITS(192)) u_k192 (
    .clk(clk), .rst(rst), .start(start_s[1]), .key(key_s[191:0]),
    .busy(busy_s[1]), .done(done_s[1]), .rk_addr(addr_s[1]), .rk_data(data_s[1]));
  aes_key_expand #(.KEY_BITS(256)) u_k256 (
    .clk(clk), .rst(rst), .start(start_s[2]), .key(key_s),
    .busy(busy_s[2]), .done(done_s[2]), .rk_addr(addr_s[2]), .rk_data(data_s[2]));

  typedef struct { int d; logic [3:0] a; logic [127:0] exp; } rd_t;
  typedef struct { int d; logic [255:0] k; int edges; } ex_t;

  localparam logic [255:0] K128  = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] K128B = 256'hc2f45dfa8acd3f4da3dcfe8a93cefa0a;

  rd_t sb[$];
  rd_t rtab[12];
  ex_t etab[3];
  int  nvec = 0;
  int  nerr = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic rd(input int d, input logic [3:0] a, input logic [127:0] exp);
    rd_t e;
    @(negedge clk);
    addr_s[d] = a;
    sb.push_back('{d, a, exp});
    @(posedge clk); #1;
    e = sb.pop_front();
    chk($sformatf("rk dut%0d addr%0d", e.d, e.a), data_s[e.d], e.exp);
  endtask

  task automatic launch(input int d, input logic [255:0] k);
    @(negedge clk);
    key_s = k;
    start_s[d] = 1'b1;
    @(posedge clk); #1;
    start_s[d] = 1'b0;
  endtask

  // Returns the GEN edge count after which done is seen, -1 on timeout.
  task automatic wait_done(input int d, input int pulse_at, output int n);
    n = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (done_s[d]) begin n = c; break; end
      start_s[d] = (c == pulse_at);
      if (c == pulse_at) key_s = {8{32'hdeadbeef}};
    end
    start_s[d] = 1'b0;
  endtask

  initial begin
    int n;
    bit saw_done;
    for (int d = 0; d < 3; d++) addr_s[d] = 4'd0;

    etab[0] = '{0, K128, 40};
    etab[1] = '{1, 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 46};
    etab[2] = '{2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 52};

    rtab[0]  = '{0, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    rtab[1]  = '{0, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    rtab[2]  = '{0, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    rtab[3]  = '{0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    rtab[4]  = '{0, 4'd11, 128'h0};
    rtab[5]  = '{1, 4'd0,  128'h8e73b0f7da0e6452c810f32b809079e5};
    rtab[6]  = '{1, 4'd12, 128'he98ba06f448c773c8ecc720401002202};
    rtab[7]  = '{1, 4'd13, 128'h0};
    rtab[8]  = '{2, 4'd0,  128'h603deb1015ca71be2b73aef0857d7781};
    rtab[9]  = '{2, 4'd1,  128'h1f352c073b6108d72d9810a30914dff4};
    rtab[10] = '{2, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e};
    rtab[11] = '{2, 4'd15, 128'h0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset busy dut%0d", d), 128'(busy_s[d]), 128'h0);
      chk($sformatf("reset done dut%0d", d), 128'(done_s[d]), 128'h0);
      chk($sformatf("reset rk dut%0d", d), data_s[d], 128'h0);
    end
    @(negedge clk); rst = 1'b0;

    // One expansion per key size, then the read table
    for (int e = 0; e < 3; e++) begin
      launch(etab[e].d, etab[e].k);
      chk($sformatf("busy after E0 dut%0d", etab[e].d), 128'(busy_s[etab[e].d]), 128'h1);
      wait_done(etab[e].d, 0, n);
      chk($sformatf("done edge dut%0d", etab[e].d), 128'(n), 128'(etab[e].edges));
      chk($sformatf("busy at done dut%0d", etab[e].d), 128'(busy_s[etab[e].d]), 128'h0);
      @(posedge clk); #1;
      chk($sformatf("done width dut%0d", etab[e].d), 128'(done_s[etab[e].d]), 128'h0);
    end
    for (int r = 0; r < 12; r++) rd(rtab[r].d, rtab[r].a, rtab[r].exp);

    // Back-to-back: second start during the done cycle, plus ignored mid-GEN start
    launch(0, K128);
    wait_done(0, 0, n);
    chk("b2b first done", 128'(n), 128'd40);
    launch(0, K128B);
    chk("b2b no gap busy", 128'(busy_s[0]), 128'h1);
    chk("b2b no gap done", 128'(done_s[0]), 128'h0);
    wait_done(0, 20, n);
    chk("b2b second done", 128'(n), 128'd40);
    @(posedge clk); #1;
    chk("mid start not queued", 128'(busy_s[0]), 128'h0);
    rd(0, 4'd0, K128B[127:0]);

    // Reset at GEN edge 20 aborts; store clears and done never fires
    launch(0, K128);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    #2;
    chk("abort busy", 128'(busy_s[0]), 128'h0);
    chk("abort done", 128'(done_s[0]), 128'h0);
    @(negedge clk); rst = 1'b0;
    saw_done = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      if (done_s[0]) saw_done = 1'b1;
    end
    chk("abort no done", 128'(saw_done), 128'h0);
    for (int a = 0; a <= 10; a++) rd(0, 4'(a), 128'h0);
    launch(0, K128);
    wait_done(0, 0, n);
    chk("after abort done", 128'(n), 128'd40);
    rd(0, 4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
    rd(0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
